spi_target: RTL and testbench

- SPI mode-0 target (peripheral side) of the SPI link that the card's SPI master drives.
- Oversamples sclk, mosi and _ss in the clk domain.
- Deserialises bytes MSB-first into an RX holding register and serialises bytes from a TX holding register onto miso.
- Used as the responder for bench loopback of the master, and as the slave-side link to the on-card microcontroller.

---
 rtl/spi_target_if.sv | 33 +++
 rtl/spi_target.sv | 181 ++++++++++++++++++
 tb/tb_spi_target.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// SPI pin and host-side register bus of spi_target.
// The slave modport is the target's view; the master modport is the driver/host view.
interface spi_target_if;
  logic        sclk;
  logic        mosi;
  logic        _ss;
  logic        miso;
  logic        miso_oe;
  logic        selected;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        rx_overrun;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic        tx_underrun;
  logic        clr_flags;
  logic        crc_clr;
  logic [15:0] crc_out;

  modport slave (
    input  sclk, mosi, _ss, rx_ack, tx_data, tx_load, clr_flags, crc_clr,
    output miso, miso_oe, selected, rx_data, rx_valid, rx_overrun,
           tx_ready, tx_underrun, crc_out
  );

  modport master (
    output sclk, mosi, _ss, rx_ack, tx_data, tx_load, clr_flags, crc_clr,
    input  miso, miso_oe, selected, rx_data, rx_valid, rx_overrun,
           tx_ready, tx_underrun, crc_out
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled sclk/mosi/_ss, MSB-first RX/TX holding registers.
// Optional CRC-16/XMODEM over received bits is built when SPI_TARGET_CRC16_EN is defined.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic         clk,
  input  logic         rst,
  spi_target_if.slave  bus
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic       r_sclk_prev, r_ss_prev;
  logic       w_sclk, w_mosi, w_ss;
  logic       w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic       w_consume, w_sample, w_shift_out, w_abort, w_byte_done;
  logic [7:0] w_rx_byte, w_load_byte;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [6:0] r_tx_shift;
  logic [7:0] r_tx_hold;
  logic [7:0] r_rx_data;
  logic       r_miso, r_miso_oe, r_rx_valid, r_rx_overrun, r_tx_ready, r_tx_underrun;

  // Synchroniser stage: _ss resets to the deselected level so reset never looks like a select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus._ss};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_ss_rise   = w_ss & ~r_ss_prev;
  assign w_ss_fall   = ~w_ss & r_ss_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    w_sample    = 1'b0;
    w_shift_out = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_SHIFT;
          w_consume   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_sample = w_sclk_rise;
          if (w_sclk_fall) begin
            if (r_bit_cnt == 3'd0) w_consume   = 1'b1;
            else                   w_shift_out = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_byte_done = w_sample & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift, w_mosi};
  assign w_load_byte = r_tx_ready ? IDLE_FILL : r_tx_hold;

  // Shift stage: bit counter, RX/TX shifters and the miso pin register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 7'd0;
      r_miso     <= 1'b1;
      r_miso_oe  <= 1'b0;
    end else if (w_abort) begin
      r_bit_cnt <= 3'd0;
      r_miso    <= 1'b1;
      r_miso_oe <= 1'b0;
    end else begin
      if (w_sample) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_consume) begin
        r_tx_shift <= w_load_byte[6:0];
        r_miso     <= w_load_byte[7];
        r_miso_oe  <= 1'b1;
      end else if (w_shift_out) begin
        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end
    end
  end

  // Holding registers and sticky flags; a set always beats clr_flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data     <= 8'd0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_hold     <= 8'd0;
      r_tx_ready    <= 1'b1;
      r_tx_underrun <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (bus.rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (w_byte_done && r_rx_valid && !bus.rx_ack) r_rx_overrun <= 1'b1;
      else if (bus.clr_flags)                       r_rx_overrun <= 1'b0;

      if (bus.tx_load && (r_tx_ready || w_consume)) begin
        r_tx_hold  <= bus.tx_data;
        r_tx_ready <= 1'b0;
      end else if (w_consume) begin
        r_tx_ready <= 1'b1;
      end
      if (w_consume && r_tx_ready) r_tx_underrun <= 1'b1;
      else if (bus.clr_flags)      r_tx_underrun <= 1'b0;
    end
  end

`ifdef SPI_TARGET_CRC16_EN
  logic [15:0] r_crc;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // CRC stage: every sampled bit counts, including those of aborted bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_crc <= 16'h0000;
    else if (bus.crc_clr)  r_crc <= 16'h0000;
    else if (w_sample)     r_crc <= crc16_step(r_crc, w_mosi);
  end

  assign bus.crc_out = r_crc;
`else
  assign bus.crc_out = 16'h0000;
`endif

  assign bus.miso        = r_miso;
  assign bus.miso_oe     = r_miso_oe;
  assign bus.selected    = ~w_ss;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_overrun  = r_rx_overrun;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed scenarios plus randomized transfers, checked against
// a transaction-level model of the holding registers, flags and CRC.
module tb_spi_target;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model
  logic [7:0]  m_hold;
  bit          m_full;
  logic [7:0]  m_rx_data;
  bit          m_rx_valid, m_ovr, m_udr;
  logic [15:0] m_crc;
  logic [7:0]  q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void m_reset();
    m_hold = 8'h00; m_full = 0; m_rx_data = 8'h00;
    m_rx_valid = 0; m_ovr = 0; m_udr = 0; m_crc = 16'h0000;
  endfunction

  function automatic logic [7:0] m_consume();
    if (m_full) begin
      m_full = 0;
      return m_hold;
    end
    m_udr = 1;
    return 8'hFF;
  endfunction

  function automatic void m_crc_bit(input logic b);
    m_crc = (m_crc << 1) ^ ((m_crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] exp_crc();
`ifdef SPI_TARGET_CRC16_EN
    return m_crc;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic load_tx(input logic [7:0] d);
    bus.tx_data = d; bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
    if (!m_full) begin m_hold = d; m_full = 1; end
    tick(1);
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
    m_rx_valid = 0;
    tick(1);
  endtask

  task automatic clear_flags();
    bus.clr_flags = 1'b1; tick(1); bus.clr_flags = 1'b0;
    m_ovr = 0; m_udr = 0;
    tick(1);
  endtask

  // Full transfer of the bytes in q; the last falling sclk coincides with _ss rising,
  // so no byte-boundary reload happens at the end. ack_idx selects the byte whose
  // completion cycle carries an rx_ack pulse (-1 for none).
  task automatic xfer(input int ack_idx);
    logic [7:0] exp_b, got;
    int last;
    last = q.size() - 1;
    bus._ss = 1'b0;
    exp_b = m_consume();
    tick(8);
    for (int k = 0; k <= last; k++) begin
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        bus.mosi = q[k][i];
        tick(4);
        bus.sclk = 1'b1;
        got[i] = bus.miso;
        m_crc_bit(q[k][i]);
        if (k == 0 && i == 7) chk("sel_oe", 32'({bus.miso_oe, bus.selected}), 32'h3);
        if (i == 0 && k == ack_idx) begin
          tick(2); bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0; tick(1);
        end else begin
          tick(4);
        end
        bus.sclk = 1'b0;
        if (i == 0 && k == last) bus._ss = 1'b1;
      end
      if (m_rx_valid && k != ack_idx) m_ovr = 1;
      m_rx_data = q[k];
      m_rx_valid = 1;
      chk("miso_byte", 32'(got), 32'(exp_b));
      if (k != last) exp_b = m_consume();
    end
    tick(8);
  endtask

  // Sends the top nbits of b, then deselects mid-byte
  task automatic partial(input logic [7:0] b, input int nbits);
    bus._ss = 1'b0;
    void'(m_consume());
    tick(8);
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi = b[i];
      tick(4);
      bus.sclk = 1'b1;
      m_crc_bit(b[i]);
      tick(4);
      bus.sclk = 1'b0;
      if (i == 8 - nbits) bus._ss = 1'b1;
    end
    tick(8);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".rx_data"},     32'(bus.rx_data),     32'(m_rx_data));
    chk({tag, ".rx_valid"},    32'(bus.rx_valid),    32'(m_rx_valid));
    chk({tag, ".rx_overrun"},  32'(bus.rx_overrun),  32'(m_ovr));
    chk({tag, ".tx_ready"},    32'(bus.tx_ready),    32'(!m_full));
    chk({tag, ".tx_underrun"}, 32'(bus.tx_underrun), 32'(m_udr));
    chk({tag, ".idle_pins"},   32'({bus.miso, bus.miso_oe, bus.selected}), 32'h4);
    chk({tag, ".crc_out"},     32'(bus.crc_out),     32'(exp_crc()));
  endtask

  initial begin
    int n, ai;
    rst = 1'b1;
    bus.sclk = 1'b0; bus.mosi = 1'b0; bus._ss = 1'b1;
    bus.rx_ack = 1'b0; bus.tx_data = 8'h00; bus.tx_load = 1'b0;
    bus.clr_flags = 1'b0; bus.crc_clr = 1'b0;
    m_reset();
    #1;
    check_state("reset");
    tick(3);
    rst = 1'b0;
    tick(4);

    // Single byte with a preloaded reply
    load_tx(8'hA5);
    chk("tx_ready_loaded", 32'(bus.tx_ready), 32'h0);
    q = {}; q.push_back(8'h3C);
    xfer(-1);
    check_state("single");
    chk("single.rx_data_const", 32'(bus.rx_data), 32'h3C);
    ack();
    chk("ack_clears", 32'(bus.rx_valid), 32'h0);

    // Back-to-back bytes, nothing loaded, nothing acked
    q = {}; q.push_back(8'h11); q.push_back(8'h22);
    xfer(-1);
    check_state("b2b");
    chk("b2b.flags_const", 32'({bus.rx_overrun, bus.tx_underrun}), 32'h3);
    clear_flags();
    check_state("clr");
    ack();

    // Aborted partial byte followed by a full byte
    partial(8'hF0, 5);
    check_state("abort");
    q = {}; q.push_back(8'h81);
    xfer(-1);
    check_state("after_abort");
    ack();
    clear_flags();

    // rx_ack coincident with completion of the second byte
    q = {}; q.push_back(8'($urandom)); q.push_back(8'h55);
    xfer(1);
    check_state("ack_coinc");
    chk("ack_coinc.ovr_const", 32'(bus.rx_overrun), 32'h0);
    ack();
    clear_flags();

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(1) == 1) load_tx(8'($urandom));
      if ($urandom_range(3) == 0) load_tx(8'($urandom));
      n = int'($urandom_range(1, 3));
      q = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      ai = int'($urandom_range(0, n)) - 1;
      xfer(ai);
      check_state("rand");
      if ($urandom_range(1) == 1) ack();
      if ($urandom_range(1) == 1) clear_flags();
    end

    // CRC over ASCII "123456789"
    bus.crc_clr = 1'b1; tick(1); bus.crc_clr = 1'b0; tick(1);
    m_crc = 16'h0000;
    chk("crc_clr", 32'(bus.crc_out), 32'h0);
    q = {};
    for (int k = 0; k < 9; k++) q.push_back(8'(8'h31 + k));
    xfer(-1);
    check_state("crc");
`ifdef SPI_TARGET_CRC16_EN
    chk("crc_known", 32'(bus.crc_out), 32'h31C3);
`else
    chk("crc_known", 32'(bus.crc_out), 32'h0000);
`endif

    // Asynchronous reset in the middle of a byte
    load_tx(8'h5A);
    bus._ss = 1'b0;
    void'(m_consume());
    load_tx(8'hC3);
    tick(6);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = i[0]; tick(4); bus.sclk = 1'b1; tick(4); bus.sclk = 1'b0;
    end
    chk("pre_rst.oe", 32'(bus.miso_oe), 32'h1);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("rst_async.miso",     32'(bus.miso),     32'h1);
    chk("rst_async.miso_oe",  32'(bus.miso_oe),  32'h0);
    chk("rst_async.rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_async.tx_ready", 32'(bus.tx_ready), 32'h1);
    chk("rst_async.ovr",      32'(bus.rx_overrun), 32'h0);
    bus._ss = 1'b1; bus.sclk = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check_state("post_rst");
    load_tx(8'h96);
    q = {}; q.push_back(8'h6B);
    xfer(-1);
    check_state("post_rst_xfer");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
